fc_loader: RTL and testbench

Write-side front end for the fully connected stage. Accepts a layer configuration and a byte stream with a valid/ready handshake. Scatters the leading ifmap bytes and the following weight bytes into the FC ifmap buffer and FC weight buffer write ports, issues a one-cycle start to the FC engine, and holds busy until the engine reports its last output node.

---
 rtl/fc_loader.sv | 176 +++++++++++++++++
 tb/tb_fc_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_loader.sv
// Write-side front end of the FC stage: takes a layer config, scatters the ifmap
// bytes and the weight rows into their buffers, starts the engine and waits for its last node.
module fc_loader #(
    parameter int DW       = 8,
    parameter int WBUF_AW  = 17,
    parameter int IFMAP_AW = 10,
    parameter int FC_SIZE  = 120,
    parameter int MAX_IN   = 128,
    parameter int MAX_OUT  = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid_i,
    input  logic [8:0]          cfg_in_node_i,
    input  logic [6:0]          cfg_out_node_i,
    input  logic [1:0]          cfg_nth_fully_i,
    input  logic                s_valid_i,
    input  logic [DW-1:0]       s_data_i,
    output logic                s_ready_o,
    output logic                ifmap_wren_o,
    output logic [IFMAP_AW-1:0] ifmap_wrptr_o,
    output logic [DW-1:0]       ifmap_wdata_o,
    output logic                wbuf_wren_o,
    output logic [WBUF_AW-1:0]  wbuf_wrptr_o,
    output logic [DW-1:0]       wbuf_wdata_o,
    output logic                start_o,
    output logic [8:0]          in_node_num_o,
    output logic [6:0]          out_node_num_o,
    output logic [1:0]          nth_fully_o,
    input  logic                fc_valid_i,
    input  logic                fc_last_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_IFMAP = 3'd1,
        LD_WGT   = 3'd2,
        START    = 3'd3,
        RUN      = 3'd4
    } state_t;

    state_t              state_q;
    logic [8:0]          in_node_q;
    logic [6:0]          out_node_q;
    logic [1:0]          nth_q;
    logic [8:0]          cnt_q;       // ifmap byte index, then weight row index
    logic [6:0]          col_q;
    logic [WBUF_AW-1:0]  row_base_q;  // running i*FC_SIZE, avoids a multiplier
    logic                ifmap_wren_q;
    logic [IFMAP_AW-1:0] ifmap_wrptr_q;
    logic [DW-1:0]       ifmap_wdata_q;
    logic                wbuf_wren_q;
    logic [WBUF_AW-1:0]  wbuf_wrptr_q;
    logic [DW-1:0]       wbuf_wdata_q;
    logic                start_q;
    logic                done_q;
    logic                err_q;

    logic xfer_s;
    logic cfg_ok_s;
    logic last_row_s;
    logic last_col_s;

    assign s_ready_o  = (state_q == LD_IFMAP) || (state_q == LD_WGT);
    assign busy_o     = (state_q != IDLE);
    assign xfer_s     = s_valid_i && s_ready_o;
    assign cfg_ok_s   = (cfg_in_node_i >= 9'd1) && (cfg_in_node_i <= 9'(MAX_IN)) &&
                        (cfg_out_node_i >= 7'd1) && (cfg_out_node_i <= 7'(MAX_OUT));
    assign last_row_s = (cnt_q == (in_node_q - 9'd1));
    assign last_col_s = (col_q == (out_node_q - 7'd1));

    assign ifmap_wren_o   = ifmap_wren_q;
    assign ifmap_wrptr_o  = ifmap_wrptr_q;
    assign ifmap_wdata_o  = ifmap_wdata_q;
    assign wbuf_wren_o    = wbuf_wren_q;
    assign wbuf_wrptr_o   = wbuf_wrptr_q;
    assign wbuf_wdata_o   = wbuf_wdata_q;
    assign start_o        = start_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign in_node_num_o  = in_node_q;
    assign out_node_num_o = out_node_q;
    assign nth_fully_o    = nth_q;

    // Load-sequencing FSM with registered write ports and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            in_node_q     <= 9'd0;
            out_node_q    <= 7'd0;
            nth_q         <= 2'd0;
            cnt_q         <= 9'd0;
            col_q         <= 7'd0;
            row_base_q    <= '0;
            ifmap_wren_q  <= 1'b0;
            ifmap_wrptr_q <= '0;
            ifmap_wdata_q <= '0;
            wbuf_wren_q   <= 1'b0;
            wbuf_wrptr_q  <= '0;
            wbuf_wdata_q  <= '0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            ifmap_wren_q <= 1'b0;
            wbuf_wren_q  <= 1'b0;
            start_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid_i) begin
                        if (cfg_ok_s) begin
                            in_node_q  <= cfg_in_node_i;
                            out_node_q <= cfg_out_node_i;
                            nth_q      <= cfg_nth_fully_i;
                            cnt_q      <= 9'd0;
                            col_q      <= 7'd0;
                            row_base_q <= '0;
                            state_q    <= LD_IFMAP;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LD_IFMAP: begin
                    if (xfer_s) begin
                        ifmap_wren_q  <= 1'b1;
                        ifmap_wrptr_q <= IFMAP_AW'(cnt_q);
                        ifmap_wdata_q <= s_data_i;
                        if (last_row_s) begin
                            cnt_q   <= 9'd0;
                            state_q <= LD_WGT;
                        end else begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                    end
                end
                LD_WGT: begin
                    if (xfer_s) begin
                        wbuf_wren_q  <= 1'b1;
                        wbuf_wrptr_q <= row_base_q + WBUF_AW'(col_q);
                        wbuf_wdata_q <= s_data_i;
                        if (last_col_s) begin
                            col_q      <= 7'd0;
                            row_base_q <= row_base_q + WBUF_AW'(FC_SIZE);
                            cnt_q      <= cnt_q + 9'd1;
                            if (last_row_s) begin
                                state_q <= START;
                            end
                        end else begin
                            col_q <= col_q + 7'd1;
                        end
                    end
                end
                START: begin
                    start_q <= 1'b1;
                    state_q <= RUN;
                end
                RUN: begin
                    if (fc_valid_i && fc_last_i) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_loader.sv
// Directed self-checking bench for fc_loader: load patterns, stalls, full-size load,
// run/done handshake, config rejection and mid-load reset.
module tb_fc_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [8:0]  cfg_in;
    logic [6:0]  cfg_out;
    logic [1:0]  cfg_nth;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready_o;
    logic        ifmap_wren_o;
    logic [9:0]  ifmap_wrptr_o;
    logic [7:0]  ifmap_wdata_o;
    logic        wbuf_wren_o;
    logic [16:0] wbuf_wrptr_o;
    logic [7:0]  wbuf_wdata_o;
    logic        start_o;
    logic [8:0]  in_node_num_o;
    logic [6:0]  out_node_num_o;
    logic [1:0]  nth_fully_o;
    logic        fc_valid;
    logic        fc_last;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int overlap   = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int if_addr[$];
    int if_data[$];
    int wb_addr[$];
    int wb_data[$];

    fc_loader dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid_i    (cfg_valid),
        .cfg_in_node_i  (cfg_in),
        .cfg_out_node_i (cfg_out),
        .cfg_nth_fully_i(cfg_nth),
        .s_valid_i      (s_valid),
        .s_data_i       (s_data),
        .s_ready_o      (s_ready_o),
        .ifmap_wren_o   (ifmap_wren_o),
        .ifmap_wrptr_o  (ifmap_wrptr_o),
        .ifmap_wdata_o  (ifmap_wdata_o),
        .wbuf_wren_o    (wbuf_wren_o),
        .wbuf_wrptr_o   (wbuf_wrptr_o),
        .wbuf_wdata_o   (wbuf_wdata_o),
        .start_o        (start_o),
        .in_node_num_o  (in_node_num_o),
        .out_node_num_o (out_node_num_o),
        .nth_fully_o    (nth_fully_o),
        .fc_valid_i     (fc_valid),
        .fc_last_i      (fc_last),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // record every write and pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (ifmap_wren_o) begin
            if_addr.push_back(int'(ifmap_wrptr_o));
            if_data.push_back(int'(ifmap_wdata_o));
        end
        if (wbuf_wren_o) begin
            wb_addr.push_back(int'(wbuf_wrptr_o));
            wb_data.push_back(int'(wbuf_wdata_o));
        end
        if (start_o) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
            if (ifmap_wren_o || wbuf_wren_o) overlap = overlap + 1;
        end
        if (done_o) done_cnt = done_cnt + 1;
        if (err_o) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ibyte(input int k);
        return 8'(k * 37 + 11);
    endfunction

    function automatic logic [7:0] wbyte(input int p);
        return 8'(p * 13 + 5) ^ 8'hA5;
    endfunction

    // present one config for one cycle; returns at posedge+1
    task automatic send_cfg(input int n, input int m, input int nth);
        cfg_valid = 1'b1;
        cfg_in    = 9'(n);
        cfg_out   = 7'(m);
        cfg_nth   = 2'(nth);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic stream(input int n, input int m, input bit stall, input int lim);
        int idx;
        int guard;
        int total;
        bit v;
        idx   = 0;
        guard = 0;
        total = n + n * m;
        if (lim < total) total = lim;
        while (idx < total && guard < 60000) begin
            v       = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data  = (idx < n) ? ibyte(idx) : wbyte(idx - n);
            @(negedge clk);
            if (v && s_ready_o) begin
                if (idx == total - 1) last_acc = cyc;
                idx = idx + 1;
            end
            @(posedge clk); #1;
            guard = guard + 1;
        end
        s_valid = 1'b0;
        chk("stream_count", 32'(idx), 32'(total));
    endtask

    task automatic verify_load(input int n, input int m, input int ib, input int wb);
        int ni;
        int nw;
        ni = if_addr.size() - ib;
        nw = wb_addr.size() - wb;
        chk("ifmap_wr_count", 32'(ni), 32'(n));
        chk("wbuf_wr_count", 32'(nw), 32'(n * m));
        for (int k = 0; k < n && k < ni; k++) begin
            chk("ifmap_addr", 32'(if_addr[ib + k]), 32'(k));
            chk("ifmap_data", 32'(if_data[ib + k]), 32'(ibyte(k)));
        end
        for (int p = 0; p < n * m && p < nw; p++) begin
            chk("wbuf_addr", 32'(wb_addr[wb + p]), 32'((p / m) * 120 + (p % m)));
            chk("wbuf_data", 32'(wb_data[wb + p]), 32'(wbyte(p)));
        end
    endtask

    // full load then check start pulse and latched counts; leaves DUT in RUN
    task automatic do_load(input int n, input int m, input int nth, input bit stall);
        int ib;
        int wb;
        int sc;
        ib = if_addr.size();
        wb = wb_addr.size();
        sc = start_cnt;
        send_cfg(n, m, nth);
        chk("ready_after_cfg", 32'(s_ready_o), 32'd1);
        stream(n, m, stall, 1 << 30);
        repeat (3) @(posedge clk);
        #1;
        chk("start_count", 32'(start_cnt - sc), 32'd1);
        chk("start_latency", 32'(start_cyc - last_acc), 32'd2);
        chk("start_wren_overlap", 32'(overlap), 32'd0);
        chk("in_node_num", 32'(in_node_num_o), 32'(n));
        chk("out_node_num", 32'(out_node_num_o), 32'(m));
        chk("nth_fully", 32'(nth_fully_o), 32'(nth));
        chk("busy_in_run", 32'(busy_o), 32'd1);
        verify_load(n, m, ib, wb);
    endtask

    task automatic finish_run();
        fc_valid = 1'b1;
        fc_last  = 1'b1;
        @(posedge clk); #1;
        fc_valid = 1'b0;
        fc_last  = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("busy_after_done", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_one_cycle", 32'(done_o), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int ib;
        int ec;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_in    = 9'd0;
        cfg_out   = 7'd0;
        cfg_nth   = 2'd0;
        s_valid   = 1'b0;
        s_data    = 8'd0;
        fc_valid  = 1'b0;
        fc_last   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'($countones({s_ready_o, ifmap_wren_o, ifmap_wrptr_o,
            ifmap_wdata_o, wbuf_wren_o, wbuf_wrptr_o, wbuf_wdata_o, start_o, in_node_num_o,
            out_node_num_o, nth_fully_o, busy_o, done_o, err_o})), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // N=4, M=3 without stalls, then the RUN phase with an ignored config
        do_load(4, 3, 1, 1'b0);
        ib = if_addr.size();
        ec = err_cnt;
        fc_valid  = 1'b1;
        fc_last   = 1'b0;
        cfg_valid = 1'b1;
        cfg_in    = 9'd7;
        cfg_out   = 7'd5;
        cfg_nth   = 2'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("run_busy", 32'(busy_o), 32'd1);
            chk("run_no_done", 32'(done_o), 32'd0);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        chk("run_cfg_ignored", 32'(in_node_num_o), 32'd4);
        chk("run_no_err", 32'(err_cnt - ec), 32'd0);
        chk("run_no_writes", 32'(if_addr.size() - ib), 32'd0);
        finish_run();

        // same load with random stalls
        do_load(4, 3, 1, 1'b1);
        finish_run();

        // maximum-size load
        do_load(128, 120, 2, 1'b0);
        chk("last_wbuf_addr", 32'(wb_addr[wb_addr.size() - 1]), 32'd15359);
        finish_run();

        // rejected configurations
        ib = if_addr.size() + wb_addr.size();
        send_cfg(0, 3, 0);
        @(negedge clk);
        chk("err_in0", 32'(err_o), 32'd1);
        chk("err_in0_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        send_cfg(129, 3, 0);
        @(negedge clk);
        chk("err_in129", 32'(err_o), 32'd1);
        chk("err_in129_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        send_cfg(4, 0, 0);
        @(negedge clk);
        chk("err_out0", 32'(err_o), 32'd1);
        chk("err_out0_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_one_cycle", 32'(err_o), 32'd0);
        chk("err_no_writes", 32'(if_addr.size() + wb_addr.size() - ib), 32'd0);
        @(posedge clk); #1;

        // reset in the middle of the weight load, then restart
        send_cfg(4, 3, 1);
        stream(4, 3, 1'b0, 8);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midload_reset_outputs", 32'($countones({s_ready_o, ifmap_wren_o, ifmap_wrptr_o,
            ifmap_wdata_o, wbuf_wren_o, wbuf_wrptr_o, wbuf_wdata_o, start_o, in_node_num_o,
            out_node_num_o, nth_fully_o, busy_o, done_o, err_o})), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_load(2, 2, 3, 1'b0);
        finish_run();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
